// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched shared definitions.
// State encoding and widths shared with the FIFO top and UART TX.
package fifo_rd_sched_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POP       = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_e;

   function automatic int cnt_width(input int gap_w, input int ack_to);
      int tw;
      tw = $clog2(ack_to);
      if (tw < 1) tw = 1;
      return (gap_w > tw) ? gap_w : tw;
   endfunction

endpackage

// File: rtl/fifo_rd_sched_if.sv
// fifo_rd_sched bus bundle.
// FIFO read side, gap config and consumer handshake.
interface fifo_rd_sched_if
   import fifo_rd_sched_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int GAP_WIDTH  = 4,
   parameter int CNT_WIDTH  = 16
);
   logic                  en;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_rinc;
   logic [GAP_WIDTH-1:0]  gap_cfg;
   logic                  out_busy;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  ctrl_busy;
   logic                  err_timeout;
   logic [CNT_WIDTH-1:0]  word_cnt;

   modport master (
      input  en, fifo_empty, fifo_rdata, gap_cfg, out_busy,
      output fifo_rinc, out_data, out_valid, ctrl_busy,
      output err_timeout, word_cnt
   );

   modport slave (
      output en, fifo_empty, fifo_rdata, gap_cfg, out_busy,
      input  fifo_rinc, out_data, out_valid, ctrl_busy,
      input  err_timeout, word_cnt
   );
endinterface

// File: rtl/fifo_rd_sched_cnt.sv
// Loadable up/down counter.
// Shared by the ack-timeout and inter-word gap phases.
module fifo_rd_sched_cnt #(
   parameter int W = 6
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Load wins over count; up and down never requested together.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)     cnt_d = load_val_i;
      else if (inc_i) cnt_d = cnt_q + W'(1);
      else if (dec_i) cnt_d = cnt_q - W'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/fifo_rd_sched.sv
// FIFO read scheduler: pop, hand off to serial consumer,
// then hold an idle gap before the next pop.
module fifo_rd_sched
   import fifo_rd_sched_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int GAP_WIDTH   = 4,
   parameter int ACK_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 16
) (
   input  logic           CLK,
   input  logic           RST,
   fifo_rd_sched_if.master bus
);
   localparam int CW = cnt_width(GAP_WIDTH, ACK_TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  rinc_q, rinc_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;

   logic          c_load, c_inc, c_dec;
   logic [CW-1:0] c_val, c_q;

   fifo_rd_sched_cnt #(.W(CW)) u_cnt (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (c_load),
      .load_val_i (c_val),
      .inc_i      (c_inc),
      .dec_i      (c_dec),
      .cnt_o      (c_q)
   );

   // Next state, next outputs and counter control.
   always_comb begin
      state_d = state_q;
      rinc_d  = 1'b0;
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      wcnt_d  = wcnt_q;
      c_load  = 1'b0;
      c_inc   = 1'b0;
      c_dec   = 1'b0;
      c_val   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.en && !bus.fifo_empty) begin
               state_d = ST_POP;
               rinc_d  = 1'b1;
               data_d  = bus.fifo_rdata;
            end
         end
         ST_POP: begin
            valid_d = 1'b1;
            state_d = ST_WAIT_ACK;
            c_load  = 1'b1;
         end
         ST_WAIT_ACK: begin
            if (bus.out_busy) begin
               valid_d = 1'b0;
               wcnt_d  = wcnt_q + CNT_WIDTH'(1);
               state_d = ST_WAIT_DONE;
            end else if (c_q == TO_LAST) begin
               // Drop the word; shortest gap, counter loads 0.
               valid_d = 1'b0;
               err_d   = 1'b1;
               state_d = ST_GAP;
               c_load  = 1'b1;
            end else begin
               c_inc = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.out_busy) begin
               c_load  = 1'b1;
               c_val   = CW'(bus.gap_cfg);
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (c_q == '0) state_d = ST_IDLE;
            else           c_dec   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         rinc_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rinc_q  <= rinc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign bus.fifo_rinc   = rinc_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_data    = data_q;
   assign bus.err_timeout = err_q;
   assign bus.word_cnt    = wcnt_q;
   assign bus.ctrl_busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fifo_rd_sched.sv
// fifo_rd_sched bench: timestamp reference model,
// emulated FIFO and consumer, directed and random phases.
module tb_fifo_rd_sched;
   localparam int DW = 8;
   localparam int GW = 4;
   localparam int AT = 64;
   localparam int CN = 16;

   logic CLK = 1'b0;
   logic RST;

   fifo_rd_sched_if #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(CN)) bus ();

   fifo_rd_sched #(
      .DATA_WIDTH (DW),
      .GAP_WIDTH  (GW),
      .ACK_TIMEOUT(AT),
      .CNT_WIDTH  (CN)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: word in flight plus the edge index where idle resumes
   int          n = 0;
   bit          m_fly = 0, m_acked = 0;
   int          m_pop = 0, m_idle_at = 0;
   logic        m_rinc = 0, m_valid = 0, m_err = 0, m_cbusy = 0;
   logic [DW-1:0] m_data = '0;
   logic [CN-1:0] m_cnt = '0;

   // environment
   logic [DW-1:0] fq[$];
   logic pend_empty = 1'b1;
   int   cons_mode = 2;
   bit   auto_fill = 0;
   bit   c_armed = 0, c_ign = 0;
   int   c_lat = 0, c_dur = 0;
   int   rinc_cnt = 0, vcnt = 0;
   int   rcyc[$];
   logic [DW-1:0] acc[$];
   logic pv = 1'b0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s got %h exp %h cyc %0d", nm, got, exp, cyc);
      end
   endfunction

   task automatic model_step();
      if (RST) begin
         m_rinc = 0; m_valid = 0; m_err = 0; m_data = '0; m_cnt = '0;
         m_fly = 0; m_acked = 0; m_idle_at = 0;
      end else if (!m_fly && n >= m_idle_at) begin
         if (bus.en && !bus.fifo_empty) begin
            m_fly = 1; m_acked = 0; m_pop = n;
            m_rinc = 1; m_data = bus.fifo_rdata;
         end
      end else if (m_fly && n == m_pop + 1) begin
         m_rinc = 0; m_valid = 1;
      end else if (m_fly && !m_acked) begin
         if (bus.out_busy) begin
            m_valid = 0; m_acked = 1; m_cnt = m_cnt + 1'b1;
         end else if (n - m_pop - 1 == AT) begin
            m_valid = 0; m_err = 1; m_fly = 0; m_idle_at = n + 2;
         end
      end else if (m_fly && m_acked) begin
         if (!bus.out_busy) begin
            m_fly = 0; m_idle_at = n + int'(bus.gap_cfg) + 2;
         end
      end
      n++;
      m_cbusy = m_fly || (n < m_idle_at);
   endtask

   function automatic void compare();
      chk("rinc", 32'(bus.fifo_rinc), 32'(m_rinc));
      chk("valid", 32'(bus.out_valid), 32'(m_valid));
      chk("data", 32'(bus.out_data), 32'(m_data));
      chk("ctrl_busy", 32'(bus.ctrl_busy), 32'(m_cbusy));
      chk("err", 32'(bus.err_timeout), 32'(m_err));
      chk("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
   endfunction

   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      cyc++;
      compare();
      if (bus.fifo_rinc) begin
         rinc_cnt++;
         rcyc.push_back(cyc);
         chk("no_underflow", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) void'(fq.pop_front());
      end
      if (bus.out_valid) vcnt++;
      if (bus.out_valid && !pv) acc.push_back(bus.out_data);
      pv = bus.out_valid;
      if (auto_fill && fq.size() < 4 && $urandom_range(0, 3) == 0)
         fq.push_back(DW'($urandom));
      bus.fifo_empty = pend_empty;
      pend_empty = (fq.size() == 0);
      bus.fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
      if (bus.out_busy) begin
         c_dur--;
         if (c_dur <= 0) bus.out_busy = 1'b0;
      end else if (bus.out_valid && cons_mode != 1) begin
         if (!c_armed) begin
            c_armed = 1;
            c_lat = (cons_mode == 2) ? 0 : int'($urandom_range(0, 3));
            c_ign = (cons_mode == 0) && ($urandom_range(0, 15) == 0);
         end
         if (!c_ign) begin
            if (c_lat == 0) begin
               bus.out_busy = 1'b1;
               c_dur = (cons_mode == 2) ? 10 : int'($urandom_range(1, 10));
               c_armed = 0;
            end else begin
               c_lat--;
            end
         end
      end else begin
         c_armed = 0;
         if (cons_mode == 0 && $urandom_range(0, 63) == 0) begin
            bus.out_busy = 1'b1;
            c_dur = int'($urandom_range(1, 3));
         end
      end
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.out_busy = 1'b0;
      c_armed = 0; c_dur = 0;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      bus.en = 1'b1;
      bus.gap_cfg = '0;
      bus.out_busy = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_rdata = '0;

      // reset held with data waiting
      fq.push_back(8'h77);
      bus.fifo_rdata = 8'h77;
      ticks(2);
      chk("rst_rinc", 32'(bus.fifo_rinc), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_wcnt", 32'(bus.word_cnt), 32'd0);
      chk("rst_err", 32'(bus.err_timeout), 32'd0);
      chk("rst_cbusy", 32'(bus.ctrl_busy), 32'd0);
      RST = 1'b0;
      tick();
      chk("first_pop", 32'(bus.fifo_rinc), 32'd1);
      ticks(20);
      chk("first_wcnt", 32'(bus.word_cnt), 32'd1);

      // single word, gap 0
      do_reset();
      rinc_cnt = 0;
      acc.delete();
      fq.push_back(8'hA5);
      ticks(30);
      chk("single_pops", 32'(rinc_cnt), 32'd1);
      chk("single_data", 32'(acc.size() ? acc[0] : 8'h00), 32'hA5);
      chk("single_wcnt", 32'(bus.word_cnt), 32'd1);

      // burst of three with gap 3
      do_reset();
      bus.gap_cfg = 4'd3;
      rinc_cnt = 0;
      rcyc.delete();
      acc.delete();
      fq.push_back(8'h11);
      fq.push_back(8'h22);
      fq.push_back(8'h33);
      ticks(70);
      chk("burst_pops", 32'(rinc_cnt), 32'd3);
      chk("burst_w0", 32'(acc.size() > 0 ? acc[0] : 8'h00), 32'h11);
      chk("burst_w1", 32'(acc.size() > 1 ? acc[1] : 8'h00), 32'h22);
      chk("burst_w2", 32'(acc.size() > 2 ? acc[2] : 8'h00), 32'h33);
      chk("burst_sp0", 32'(rcyc.size() > 1 ? rcyc[1] - rcyc[0] : 0), 32'd17);
      chk("burst_sp1", 32'(rcyc.size() > 2 ? rcyc[2] - rcyc[1] : 0), 32'd17);
      chk("burst_wcnt", 32'(bus.word_cnt), 32'd3);

      // ack timeout then recovery
      do_reset();
      bus.gap_cfg = '0;
      cons_mode = 1;
      vcnt = 0;
      fq.push_back(8'h5A);
      ticks(80);
      chk("to_vcycles", 32'(vcnt), 32'd64);
      chk("to_err", 32'(bus.err_timeout), 32'd1);
      chk("to_wcnt", 32'(bus.word_cnt), 32'd0);
      cons_mode = 2;
      rinc_cnt = 0;
      fq.push_back(8'h6B);
      ticks(20);
      chk("to_next_pop", 32'(rinc_cnt), 32'd1);
      chk("to_next_wcnt", 32'(bus.word_cnt), 32'd1);
      chk("to_sticky", 32'(bus.err_timeout), 32'd1);

      // en dropped while a word is in flight
      do_reset();
      fq.push_back(8'hC3);
      for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
      chk("en_valid_seen", 32'(bus.out_valid), 32'd1);
      bus.en = 1'b0;
      rinc_cnt = 0;
      fq.push_back(8'hD4);
      fq.push_back(8'hE5);
      ticks(40);
      chk("en_off_pops", 32'(rinc_cnt), 32'd0);
      chk("en_off_wcnt", 32'(bus.word_cnt), 32'd1);
      bus.en = 1'b1;
      ticks(40);
      chk("en_on_pops", 32'(rinc_cnt), 32'd2);
      chk("en_on_wcnt", 32'(bus.word_cnt), 32'd3);

      // reset while waiting for busy to fall
      do_reset();
      fq.push_back(8'h99);
      for (int i = 0; i < 12 && !bus.out_busy; i++) tick();
      chk("rm_busy_seen", 32'(bus.out_busy), 32'd1);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rm_cbusy", 32'(bus.ctrl_busy), 32'd0);
      chk("rm_valid", 32'(bus.out_valid), 32'd0);
      chk("rm_wcnt", 32'(bus.word_cnt), 32'd0);
      rinc_cnt = 0;
      fq.push_back(8'hAA);
      ticks(40);
      chk("rm_pops", 32'(rinc_cnt), 32'd1);
      chk("rm_next_wcnt", 32'(bus.word_cnt), 32'd1);

      // random traffic
      cons_mode = 0;
      auto_fill = 1;
      for (int i = 0; i < 5000; i++) begin
         RST = ($urandom_range(0, 599) == 0);
         bus.en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) bus.gap_cfg = GW'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
